fb_scanout_reader: RTL and testbench

//  Read side of the SRAM framebuffer: streams the active 640x480 frame from SRAM,
//  in raster order, into the VGA pixel path.

---
 rtl/fb_scanout_reader.sv | 123 ++++++++++++
 tb/tb_fb_scanout_reader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout_reader.sv
// rtl/fb_scanout_reader.sv - SRAM framebuffer scanout: raster-order prefetch of the visible frame into a pixel FIFO.
module fb_scanout_reader #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter logic [19:0] BASE_ADDR  = 20'h0,
    parameter int          DEPTH      = 16,
    parameter logic [15:0] FILL_COLOR = 16'hF81F
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_ce,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [19:0] req_addr,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_data,
    output logic [15:0] pix_data,
    output logic        underflow,
    output logic        frame_active
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [9:0]  H_LIM    = 10'(H_RES);
    localparam logic [9:0]  V_LIM    = 10'(V_RES);
    localparam logic [18:0] LAST_PIX = 19'(H_RES * V_RES - 1);
    localparam logic [CW:0] DEPTH_W  = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t state, state_n;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count, fifo_count_n;
    logic [CW-1:0] inflight, inflight_n;
    logic [CW-1:0] drop, drop_n;
    logic [18:0]   fetch_cnt;
    logic          frame_sync, visible, accept, push, pop, req_valid_n;

    assign frame_sync = pix_ce && (DrawX == 10'd0) && (DrawY == V_LIM);
    assign visible    = pix_ce && (DrawX < H_LIM) && (DrawY < V_LIM);
    assign accept     = req_valid && req_ready;
    // Responses arriving on a frame sync belong to the old frame and are never stored.
    assign push       = rsp_valid && (drop == '0) && !frame_sync;
    assign pop        = visible && (fifo_count != '0);

    always_comb begin
        state_n      = state;
        inflight_n   = inflight + CW'(accept) - CW'(rsp_valid);
        fifo_count_n = fifo_count + CW'(push) - CW'(pop);
        drop_n       = drop;
        if (frame_sync) begin
            state_n      = FETCH;
            fifo_count_n = '0;
            // Everything still outstanding after this edge, including a same-cycle accept, is stale.
            drop_n       = inflight_n;
        end else begin
            if (state == FETCH && accept && fetch_cnt == LAST_PIX)
                state_n = DONE;
            if (rsp_valid && drop != '0)
                drop_n = drop - CW'(1);
        end
        // Computed from next-state occupancy so a registered request can never overflow the FIFO.
        req_valid_n = (state_n == FETCH) &&
                      (({1'b0, fifo_count_n} + {1'b0, inflight_n}) < DEPTH_W);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            req_valid    <= 1'b0;
            req_addr     <= '0;
            pix_data     <= '0;
            underflow    <= 1'b0;
            frame_active <= 1'b0;
            fifo_count   <= '0;
            inflight     <= '0;
            drop         <= '0;
            fetch_cnt    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            state      <= state_n;
            req_valid  <= req_valid_n;
            fifo_count <= fifo_count_n;
            inflight   <= inflight_n;
            drop       <= drop_n;
            if (frame_sync) begin
                req_addr     <= BASE_ADDR;
                fetch_cnt    <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                underflow    <= 1'b0;
                frame_active <= 1'b1;
            end else begin
                if (accept) begin
                    req_addr  <= req_addr + 20'd1;
                    fetch_cnt <= fetch_cnt + 19'd1;
                end
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (state == DONE && fifo_count == '0 && inflight == '0)
                    frame_active <= 1'b0;
            end
            if (visible) begin
                if (pop) begin
                    pix_data <= mem[rd_ptr];
                end else begin
                    pix_data  <= FILL_COLOR;
                    underflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= rsp_data;
    end
endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb/tb_fb_scanout_reader.sv - Directed bench for fb_scanout_reader with a queue-based frame model and SRAM responder.
module tb_fb_scanout_reader;
    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          D    = 16;
    localparam logic [19:0] BASE = 20'hFFFF0;
    localparam logic [15:0] FILL = 16'hF81F;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [15:0] rsp_data = '0;
    logic        req_valid;
    logic [19:0] req_addr;
    logic [15:0] pix_data;
    logic        underflow;
    logic        frame_active;

    fb_scanout_reader #(
        .H_RES(H), .V_RES(V), .BASE_ADDR(BASE), .DEPTH(D), .FILL_COLOR(FILL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .DrawX(DrawX), .DrawY(DrawY),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .pix_data(pix_data),
        .underflow(underflow), .frame_active(frame_active)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] memw(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], a[19:16], 8'hC3};
    endfunction

    // SRAM responder: fixed latency, in order, can be held off entirely.
    typedef struct {int due; logic [15:0] d;} rsp_t;
    rsp_t rq[$];
    int   lat = 0;
    bit   hold = 1'b0;
    int   acc_cnt = 0;
    initial begin
        rsp_t e;
        forever begin
            @(negedge Clk);
            #1;
            rsp_valid = 1'b0;
            if (Reset) begin
                rq.delete();
            end else begin
                if (req_valid && req_ready) begin
                    e.due = cyc + lat;
                    e.d   = memw(req_addr);
                    rq.push_back(e);
                    acc_cnt++;
                end
                if (!hold && rq.size() > 0 && rq[0].due <= cyc) begin
                    rsp_valid = 1'b1;
                    rsp_data  = rq[0].d;
                    void'(rq.pop_front());
                end
            end
        end
    end

    // Frame model: outstanding requests and buffered pixels as queues of addresses/words.
    logic [19:0] m_infl[$];
    bit          m_stale[$];
    logic [15:0] m_fifo[$];
    int          m_phase = 0;
    int          m_cnt = 0;
    int          m_dropped = 0;
    logic [19:0] m_addr = '0;
    logic        m_rv = 1'b0;
    logic        m_under = 1'b0;
    logic        m_active = 1'b0;
    logic [15:0] m_pix = '0;
    bit          m_live = 1'b0;
    initial begin
        bit fs, vis, acc, quiet, s;
        logic [19:0] a;
        forever begin
            @(posedge Clk);
            if (Reset) begin
                m_infl.delete(); m_stale.delete(); m_fifo.delete();
                m_phase = 0; m_cnt = 0; m_addr = '0; m_rv = 1'b0;
                m_under = 1'b0; m_active = 1'b0; m_pix = '0; m_live = 1'b1;
            end else begin
                fs    = pix_ce && DrawX == 0 && DrawY == V;
                vis   = pix_ce && DrawX < H && DrawY < V;
                acc   = m_rv && req_ready;
                quiet = m_phase == 2 && m_fifo.size() == 0 && m_infl.size() == 0;
                if (vis) begin
                    if (m_fifo.size() > 0) m_pix = m_fifo.pop_front();
                    else begin m_pix = FILL; m_under = 1'b1; end
                end
                if (acc) begin m_infl.push_back(m_addr); m_stale.push_back(1'b0); end
                if (rsp_valid) begin
                    if (m_infl.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_without_request actual=1 expected=0 at %0t", $time);
                    end else begin
                        a = m_infl.pop_front();
                        s = m_stale.pop_front();
                        if (s) m_dropped++;
                        else if (!fs) m_fifo.push_back(memw(a));
                    end
                end
                if (fs) begin
                    m_fifo.delete();
                    foreach (m_stale[i]) m_stale[i] = 1'b1;
                    m_phase = 1; m_cnt = 0; m_addr = BASE; m_under = 1'b0; m_active = 1'b1;
                end else begin
                    if (acc) begin
                        m_addr = m_addr + 20'd1;
                        m_cnt++;
                        if (m_cnt == H * V) m_phase = 2;
                    end
                    if (quiet) m_active = 1'b0;
                end
                m_rv = (m_phase == 1) && (m_fifo.size() + m_infl.size() < D);
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (m_live && !Reset) begin
                chk("req_valid", 32'(req_valid), 32'(m_rv));
                if (m_rv) chk("req_addr", 32'(req_addr), 32'(m_addr));
                chk("pix_data", 32'(pix_data), 32'(m_pix));
                chk("underflow", 32'(underflow), 32'(m_under));
                chk("frame_active", 32'(frame_active), 32'(m_active));
                chk("fifo_count", 32'(dut.fifo_count), 32'(m_fifo.size()));
                chk("inflight", 32'(dut.inflight), 32'(m_infl.size()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic set_in(input bit ce, input int x, input int y);
        pix_ce = ce;
        DrawX  = 10'(x);
        DrawY  = 10'(y);
    endtask

    task automatic drive(input bit ce, input int x, input int y);
        @(negedge Clk);
        set_in(ce, x, y);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0);
    endtask

    task automatic frame(input int gap);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H + 2; x++) begin
                drive(1'b1, x, y);
                idle(gap);
            end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        chk({tag, "_req_addr"}, 32'(req_addr), 32'd0);
        chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
        chk({tag, "_frame_active"}, 32'(frame_active), 32'd0);
        chk({tag, "_fifo_count"}, 32'(dut.fifo_count), 32'd0);
        chk({tag, "_inflight"}, 32'(dut.inflight), 32'd0);
    endtask

    initial begin
        int base;
        int d0;
        idle(3);
        check_reset_state("rst");
        Reset = 1'b0;

        // Zero-latency responder over a whole frame, address wraps past 20'hFFFFF.
        lat = 0; hold = 1'b0; req_ready = 1'b1;
        base = acc_cnt;
        drive(1'b1, 0, V);
        idle(1);
        chk("t1_first_valid", 32'(req_valid), 32'd1);
        chk("t1_first_addr", 32'(req_addr), 32'(BASE));
        idle(20);
        frame(1);
        idle(5);
        chk("t1_req_count", 32'(acc_cnt - base), 32'(H * V));
        chk("t1_underflow", 32'(underflow), 32'd0);
        chk("t1_frame_done", 32'(frame_active), 32'd0);

        // Controller stalled for 40 cycles, then latency 3 with no pixel strobes.
        req_ready = 1'b0; lat = 3;
        drive(1'b1, 0, V);
        base = acc_cnt;
        repeat (40) begin
            idle(1);
            chk("t2_valid_held", 32'(req_valid), 32'd1);
            chk("t2_addr_held", 32'(req_addr), 32'(BASE));
            chk("t2_no_push", 32'(dut.fifo_count), 32'd0);
        end
        req_ready = 1'b1;
        idle(100);
        chk("t3_accepts", 32'(acc_cnt - base), 32'd16);
        chk("t3_fifo_full", 32'(dut.fifo_count), 32'd16);
        chk("t3_valid_low", 32'(req_valid), 32'd0);
        frame(1);
        idle(5);

        // Responder held past the first visible pop.
        lat = 1; hold = 1'b1;
        drive(1'b1, 0, V);
        idle(10);
        drive(1'b1, 0, 0);
        idle(1);
        chk("t4_fill_pixel", 32'(pix_data), 32'(FILL));
        chk("t4_underflow_set", 32'(underflow), 32'd1);
        hold = 1'b0;
        frame(1);
        chk("t4_underflow_sticky", 32'(underflow), 32'd1);
        drive(1'b1, 0, V);
        idle(1);
        chk("t4_underflow_cleared", 32'(underflow), 32'd0);

        // Frame sync while three requests are outstanding at latency 4.
        Reset = 1'b1;
        idle(2);
        Reset = 1'b0;
        lat = 4; hold = 1'b0; req_ready = 1'b1;
        drive(1'b1, 0, V);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (m_infl.size() == 3) break;
        end
        chk("t5_inflight_at_sync", 32'(dut.inflight), 32'd3);
        d0 = m_dropped;
        req_ready = 1'b0;
        set_in(1'b1, 0, V);
        idle(1);
        req_ready = 1'b1;
        idle(20);
        chk("t5_stale_dropped", 32'(m_dropped - d0), 32'd3);
        drive(1'b1, 0, 0);
        idle(1);
        chk("t5_first_pixel", 32'(pix_data), 32'(memw(BASE)));

        // Reset in the middle of a fetching frame.
        Reset = 1'b1;
        idle(1);
        check_reset_state("rst_mid");
        Reset = 1'b0;

        // Accept, response and pop on the same edge with the FIFO half full.
        lat = 0; hold = 1'b1; req_ready = 1'b1;
        drive(1'b1, 0, V);
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (m_infl.size() == 8) break;
        end
        req_ready = 1'b0; hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (m_fifo.size() == 8 && m_infl.size() == 0) break;
        end
        hold = 1'b1; req_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (m_infl.size() == 7) break;
        end
        chk("t6_pre_fifo", 32'(dut.fifo_count), 32'd8);
        chk("t6_pre_inflight", 32'(dut.inflight), 32'd7);
        chk("t6_pre_valid", 32'(req_valid), 32'd1);
        hold = 1'b0;
        set_in(1'b1, 0, 0);
        idle(1);
        req_ready = 1'b0; hold = 1'b1;
        chk("t6_post_fifo", 32'(dut.fifo_count), 32'd8);
        chk("t6_post_inflight", 32'(dut.inflight), 32'd7);
        chk("t6_head_pixel", 32'(pix_data), 32'(memw(BASE)));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
